tdm_demux_8: RTL

Receive end of an 8-channel time-division serial link. The transmit end serialises eight single-bit channels through an 8:1 multiplexer whose select is driven by a slot counter. This block recovers slot alignment from a frame-sync marker and distributes each serial bit to its channel. It presents a complete, registered 8-bit frame with a one-cycle valid pulse. It sits between the serial link input and the channel consumers.

---
 rtl/tdm_pkg.sv | 21 ++
 rtl/tdm_demux_8_lock.sv | 91 +++++++++
 rtl/tdm_demux_8.sv | 80 ++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared types and frame geometry for the TDM receive demultiplexer.
// TDM_DEMUX_PARITY_EN adds a ninth, even-parity slot to every frame.
package tdm_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } tdm_state_e;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int TDM_SLOTS = 9;
  localparam int TDM_CNT_W = 4;
`else
  localparam int TDM_SLOTS = 8;
  localparam int TDM_CNT_W = 3;
`endif

  localparam logic [TDM_CNT_W-1:0] TDM_LAST = TDM_CNT_W'(TDM_SLOTS - 1);

endpackage

// File: rtl/tdm_demux_8_lock.sv
// Slot alignment tracker: owns the slot counter, good-frame counter and lock state.
// Frame length follows TDM_DEMUX_PARITY_EN through tdm_pkg.
//
//   state  | meaning
//   HUNT   | no alignment; waiting for an accepted sync bit
//   CHECK  | aligned, counting consecutive good syncs towards lock
//   LOCKED | aligned and trusted; completed frames are published
module tdm_lock_fsm
  import tdm_pkg::*;
#(
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 sync_i,
  input  logic                 par_err_i,
  output logic [TDM_CNT_W-1:0] slot_o,
  output logic                 wr_o,
  output logic                 frame_done_o,
  output logic                 locked_o,
  output logic                 sync_err_o
);

  tdm_state_e           state_q, state_d;
  logic [TDM_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]           good_q, good_d;
  logic                 err_q, err_d;
  logic                 done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      good_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      err_q   <= err_d;
    end
  end

  assign done = en_i && (state_q == LOCKED) && (cnt_q == TDM_LAST) && !sync_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    good_d  = good_q;
    err_d   = 1'b0;
    if (en_i) begin
      if (state_q == HUNT) begin
        if (sync_i) begin
          cnt_d   = TDM_CNT_W'(1);
          good_d  = 4'd1;
          state_d = (LOCK_FRAMES == 1) ? LOCKED : CHECK;
        end
      end else if (cnt_q == '0) begin
        if (sync_i) begin
          cnt_d  = TDM_CNT_W'(1);
          good_d = (good_q == 4'd15) ? good_q : good_q + 4'd1;
          if (good_d >= 4'(LOCK_FRAMES)) state_d = LOCKED;
        end else begin
          err_d   = 1'b1;
          state_d = HUNT;
          cnt_d   = '0;
          good_d  = '0;
        end
      end else if (sync_i) begin
        // Misplaced sync restarts alignment on this very bit.
        err_d   = 1'b1;
        cnt_d   = TDM_CNT_W'(1);
        good_d  = 4'd1;
        state_d = (LOCK_FRAMES == 1) ? LOCKED : CHECK;
      end else begin
        cnt_d = (cnt_q == TDM_LAST) ? '0 : cnt_q + 1'b1;
        if (done && par_err_i) err_d = 1'b1;
      end
    end
  end

  always_comb begin
    slot_o       = sync_i ? '0 : cnt_q;
    wr_o         = en_i && ((state_q == HUNT) ? sync_i : (sync_i || (cnt_q != '0)));
    frame_done_o = done;
    locked_o     = (state_q == LOCKED);
    sync_err_o   = err_q;
  end

endmodule

// File: rtl/tdm_demux_8.sv
// 8-channel TDM receive demultiplexer: shadow capture and registered frame publish.
// TDM_DEMUX_PARITY_EN enables the ninth even-parity slot and parity-gated publish.
module tdm_demux_8
  import tdm_pkg::*;
#(
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       en,
  input  logic       sync,
  output logic [7:0] y,
  output logic       frame_valid,
  output logic       locked,
  output logic       sync_err
);

  logic [TDM_CNT_W-1:0] slot;
  logic                 wr, frame_done, par_err;
  logic [7:0]           y_q, y_d;
  logic                 fv_q, fv_d;

`ifdef TDM_DEMUX_PARITY_EN
  logic [7:0] sh_q, sh_d;
  assign par_err = ^{sh_q, din};
`else
  logic [6:0] sh_q, sh_d;
  assign par_err = 1'b0;
`endif

  tdm_lock_fsm #(.LOCK_FRAMES(LOCK_FRAMES)) u_lock (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .sync_i       (sync),
    .par_err_i    (par_err),
    .slot_o       (slot),
    .wr_o         (wr),
    .frame_done_o (frame_done),
    .locked_o     (locked),
    .sync_err_o   (sync_err)
  );

  always_comb begin
    sh_d = sh_q;
    y_d  = y_q;
    fv_d = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    if (wr && !slot[3]) sh_d[slot[2:0]] = din;
    if (frame_done && !par_err) begin
      y_d  = sh_q;
      fv_d = 1'b1;
    end
`else
    // The slot-7 bit goes straight to y, so sh only needs slots 0..6.
    if (wr && (slot != 3'd7)) sh_d[slot] = din;
    if (frame_done) begin
      y_d  = {din, sh_q};
      fv_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
      y_q  <= 8'h00;
      fv_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      y_q  <= y_d;
      fv_q <= fv_d;
    end
  end

  assign y           = y_q;
  assign frame_valid = fv_q;

endmodule
